// File: rtl/mem_req_ctrl.sv
// MEM-stage request controller: turns a load/store into one dword memory request,
// waits (bounded) for the response and returns the lane-extracted, extended load data.
module mem_req_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [2:0]  memdata_width,
  input  logic [63:0] addr,
  input  logic [63:0] wdata_aligned,
  input  logic        flush,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  output logic        req_wen,
  output logic [7:0]  req_wmask,
  output logic [63:0] req_wdata,
  input  logic        resp_valid,
  input  logic [63:0] resp_rdata,
  output logic        stall,
  output logic [63:0] load_data,
  output logic        done,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [2:0] W_NONE = 3'b000;
  localparam logic [2:0] W_D    = 3'b001;
  localparam logic [2:0] W_W    = 3'b010;
  localparam logic [2:0] W_H    = 3'b011;
  localparam logic [2:0] W_B    = 3'b100;
  localparam logic [2:0] W_WU   = 3'b101;
  localparam logic [2:0] W_HU   = 3'b110;
  localparam logic [2:0] W_BU   = 3'b111;

  localparam logic [8:0] TMO = TIMEOUT[8:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_e;

  function automatic logic is_misaligned(input logic [2:0] w, input logic [2:0] off);
    case (w)
      W_H, W_HU: is_misaligned = off[0];
      W_W, W_WU: is_misaligned = (off[1:0] != 2'b00);
      W_D:       is_misaligned = (off != 3'b000);
      default:   is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(input logic [2:0] w, input logic [2:0] off);
    case (w)
      W_D:       lane_mask = 8'hFF;
      W_W, W_WU: lane_mask = 8'h0F << off;
      W_H, W_HU: lane_mask = 8'h03 << off;
      W_B, W_BU: lane_mask = 8'h01 << off;
      default:   lane_mask = 8'h00;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend by width.
  function automatic logic [63:0] extract(input logic [2:0] w, input logic [2:0] off,
                                          input logic [63:0] rd);
    logic [63:0] sh;
    sh = rd >> {off, 3'b000};
    case (w)
      W_B:     extract = {{56{sh[7]}}, sh[7:0]};
      W_BU:    extract = {56'd0, sh[7:0]};
      W_H:     extract = {{48{sh[15]}}, sh[15:0]};
      W_HU:    extract = {48'd0, sh[15:0]};
      W_W:     extract = {{32{sh[31]}}, sh[31:0]};
      W_WU:    extract = {32'd0, sh[31:0]};
      default: extract = sh;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic        req_wen_q, req_wen_d;
  logic [7:0]  req_wmask_q, req_wmask_d;
  logic [63:0] req_wdata_q, req_wdata_d;
  logic [2:0]  width_q, width_d;
  logic [2:0]  off_q, off_d;
  logic [63:0] load_data_q, load_data_d;
  logic        bus_err_q, bus_err_d;

  logic        access;
  logic        mis;
  logic [8:0]  cnt_inc;
  logic        tmo_hit;
  logic        stall_c;
  logic        misalign_c;

  assign access  = mem_valid & (memdata_width != W_NONE) & ~flush;
  assign mis     = is_misaligned(memdata_width, addr[2:0]);
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign tmo_hit = (cnt_inc >= TMO);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_addr_d  = req_addr_q;
    req_wen_d   = req_wen_q;
    req_wmask_d = req_wmask_q;
    req_wdata_d = req_wdata_q;
    width_d     = width_q;
    off_d       = off_q;
    load_data_d = load_data_q;
    bus_err_d   = 1'b0;
    stall_c     = 1'b0;
    misalign_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (mis) begin
            misalign_c = 1'b1;
          end else begin
            req_addr_d  = {addr[63:3], 3'b000};
            req_wen_d   = mem_we;
            req_wmask_d = lane_mask(memdata_width, addr[2:0]);
            req_wdata_d = wdata_aligned;
            width_d     = memdata_width;
            off_d       = addr[2:0];
            stall_c     = 1'b1;
            state_d     = S_REQ;
          end
        end
      end

      S_REQ: begin
        stall_c = 1'b1;
        if (req_ready) begin
          cnt_d = 8'd0;
          // An accepted request owes us a response even if flushed now; drain it.
          state_d = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_inc[7:0];
        if (resp_valid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            if (!req_wen_q) load_data_d = extract(width_q, off_q, resp_rdata);
            state_d = S_DONE;
          end
        end else if (tmo_hit) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            load_data_d = 64'd0;
            bus_err_d   = 1'b1;
            state_d     = S_DONE;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        stall_c = 1'b1;
        cnt_d   = cnt_inc[7:0];
        if (resp_valid || tmo_hit) state_d = S_IDLE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      req_addr_q  <= 64'd0;
      req_wen_q   <= 1'b0;
      req_wmask_q <= 8'd0;
      req_wdata_q <= 64'd0;
      width_q     <= W_NONE;
      off_q       <= 3'd0;
      load_data_q <= 64'd0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_addr_q  <= req_addr_d;
      req_wen_q   <= req_wen_d;
      req_wmask_q <= req_wmask_d;
      req_wdata_q <= req_wdata_d;
      width_q     <= width_d;
      off_q       <= off_d;
      load_data_q <= load_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // The IDLE-cycle stall/misalign terms depend on live inputs, so mask them during reset.
  assign stall     = stall_c & ~rst;
  assign misalign  = misalign_c & ~rst;
  assign req_valid = (state_q == S_REQ);
  assign done      = (state_q == S_DONE);
  assign bus_err   = bus_err_q;
  assign req_addr  = req_addr_q;
  assign req_wen   = req_wen_q;
  assign req_wmask = req_wmask_q;
  assign req_wdata = req_wdata_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl (TIMEOUT=4): loads of every width, a stalled store,
// misalignment, flush in IDLE/REQ/WAIT, bus timeout and asynchronous reset mid-access.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_we;
  logic [2:0]  memdata_width;
  logic [63:0] addr;
  logic [63:0] wdata_aligned;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [7:0]  req_wmask;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        stall;
  logic [63:0] load_data;
  logic        done;
  logic        misalign;
  logic        bus_err;

  int n_chk  = 0;
  int n_pass = 0;

  mem_req_ctrl #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_valid     (mem_valid),
    .mem_we        (mem_we),
    .memdata_width (memdata_width),
    .addr          (addr),
    .wdata_aligned (wdata_aligned),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wen       (req_wen),
    .req_wmask     (req_wmask),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .stall         (stall),
    .load_data     (load_data),
    .done          (done),
    .misalign      (misalign),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Present an access in IDLE and confirm the same-cycle stall.
  task automatic issue(input string tag, input logic we, input logic [2:0] w,
                       input logic [63:0] a, input logic [63:0] wd);
    cyc();
    mem_valid = 1'b1; mem_we = we; memdata_width = w; addr = a; wdata_aligned = wd;
    smp();
    check({tag, ".idle_stall"}, stall, 1'b1);
    check({tag, ".idle_misalign"}, misalign, 1'b0);
  endtask

  task automatic load_access(input string tag, input logic [2:0] w, input logic [63:0] a,
                             input logic [63:0] rd, input logic [7:0] exp_mask,
                             input logic [63:0] exp_ld);
    issue(tag, 1'b0, w, a, 64'd0);
    cyc(); req_ready = 1'b1;
    smp();
    check({tag, ".req_valid"}, req_valid, 1'b1);
    check({tag, ".req_wmask"}, req_wmask, exp_mask);
    check({tag, ".req_addr"}, req_addr, {a[63:3], 3'b000});
    check({tag, ".req_wen"}, req_wen, 1'b0);
    cyc(); req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = rd;
    smp();
    check({tag, ".wait_stall"}, stall, 1'b1);
    check({tag, ".wait_done"}, done, 1'b0);
    cyc(); resp_valid = 1'b0; mem_valid = 1'b0; memdata_width = 3'b000;
    smp();
    check({tag, ".done"}, done, 1'b1);
    check({tag, ".done_stall"}, stall, 1'b0);
    check({tag, ".load_data"}, load_data, exp_ld);
    check({tag, ".bus_err"}, bus_err, 1'b0);
    cyc();
    smp();
    check({tag, ".done_pulse"}, done, 1'b0);
    check({tag, ".ld_hold"}, load_data, exp_ld);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic drained;
    rst = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; memdata_width = 3'b000; addr = 64'd0;
    wdata_aligned = 64'd0; flush = 1'b0; req_ready = 1'b0; resp_valid = 1'b0;
    resp_rdata = 64'd0;
    cyc(); cyc();
    smp();
    check("rst.req_valid", req_valid, 1'b0);
    check("rst.stall", stall, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.load_data", load_data, 64'd0);
    check("rst.req_wmask", req_wmask, 8'd0);
    check("rst.req_addr", req_addr, 64'd0);
    cyc(); rst = 1'b0;

    load_access("lb",  3'b100, 64'h0000_0000_1000_0005, 64'h0000_8000_0000_0000, 8'h20,
                64'hFFFF_FFFF_FFFF_FF80);
    load_access("lwu", 3'b101, 64'h0000_0000_2000_0004, 64'h8765_4321_0000_0000, 8'hF0,
                64'h0000_0000_8765_4321);
    load_access("lw",  3'b010, 64'h0000_0000_2000_0004, 64'h8765_4321_0000_0000, 8'hF0,
                64'hFFFF_FFFF_8765_4321);
    load_access("lhu", 3'b110, 64'h0000_0000_2000_0002, 64'h1234_5678_9ABC_DEF0, 8'h0C,
                64'h0000_0000_0000_9ABC);
    load_access("lh",  3'b011, 64'h0000_0000_2000_0002, 64'h1234_5678_9ABC_DEF0, 8'h0C,
                64'hFFFF_FFFF_FFFF_9ABC);
    load_access("lbu", 3'b111, 64'h0000_0000_2000_0007, 64'h1234_5678_9ABC_DEF0, 8'h80,
                64'h0000_0000_0000_0012);
    load_access("ld",  3'b001, 64'h0000_0000_2000_0008, 64'hCAFE_F00D_1234_5678, 8'hFF,
                64'hCAFE_F00D_1234_5678);

    // sh with req_ready held low for three REQ cycles
    issue("sh", 1'b1, 3'b011, 64'h0000_0000_3000_0006, 64'hBEEF_0000_0000_0000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      smp();
      check("sh.req_valid", req_valid, 1'b1);
      check("sh.req_wen", req_wen, 1'b1);
      check("sh.req_wmask", req_wmask, 8'hC0);
      check("sh.req_wdata", req_wdata, 64'hBEEF_0000_0000_0000);
      check("sh.req_addr", req_addr, 64'h0000_0000_3000_0000);
      check("sh.stall", stall, 1'b1);
    end
    cyc(); req_ready = 1'b1;
    smp();
    check("sh.req_valid_acc", req_valid, 1'b1);
    cyc(); req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 64'h5555_5555_5555_5555;
    smp();
    check("sh.wait_stall", stall, 1'b1);
    cyc(); resp_valid = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; memdata_width = 3'b000;
    smp();
    check("sh.done", done, 1'b1);
    check("sh.done_stall", stall, 1'b0);
    check("sh.load_data_kept", load_data, 64'hCAFE_F00D_1234_5678);

    // misaligned accesses raise misalign without a request
    cyc(); mem_valid = 1'b1; memdata_width = 3'b010; addr = 64'h0000_0000_4000_0002;
    smp();
    check("mis_lw.misalign", misalign, 1'b1);
    check("mis_lw.stall", stall, 1'b0);
    check("mis_lw.req_valid", req_valid, 1'b0);
    cyc(); memdata_width = 3'b011; addr = 64'h0000_0000_4000_0001;
    smp();
    check("mis_lh.misalign", misalign, 1'b1);
    check("mis_lh.req_valid", req_valid, 1'b0);
    cyc(); memdata_width = 3'b001; addr = 64'h0000_0000_4000_0004;
    smp();
    check("mis_ld.misalign", misalign, 1'b1);
    cyc(); mem_valid = 1'b0; memdata_width = 3'b000;
    smp();
    check("mis.pulse", misalign, 1'b0);
    check("mis.no_req", req_valid, 1'b0);
    check("mis.stall", stall, 1'b0);

    // flush in IDLE suppresses the access
    cyc(); mem_valid = 1'b1; memdata_width = 3'b010; addr = 64'h0000_0000_4000_0000;
    flush = 1'b1;
    smp();
    check("flush_idle.stall", stall, 1'b0);
    cyc(); mem_valid = 1'b0; memdata_width = 3'b000; flush = 1'b0;
    smp();
    check("flush_idle.req_valid", req_valid, 1'b0);

    // flush in REQ before acceptance returns to IDLE
    issue("flush_req", 1'b0, 3'b010, 64'h0000_0000_4000_0040, 64'd0);
    cyc(); flush = 1'b1; mem_valid = 1'b0;
    smp();
    check("flush_req.req_valid", req_valid, 1'b1);
    cyc(); flush = 1'b0; memdata_width = 3'b000;
    smp();
    check("flush_req.idle_rv", req_valid, 1'b0);
    check("flush_req.idle_stall", stall, 1'b0);
    check("flush_req.no_done", done, 1'b0);

    // timeout after four WAIT cycles
    issue("tmo", 1'b0, 3'b010, 64'h0000_0000_4000_0050, 64'd0);
    cyc(); req_ready = 1'b1;
    smp();
    check("tmo.req_valid", req_valid, 1'b1);
    cyc(); req_ready = 1'b0;
    smp();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin cyc(); smp(); end
      check("tmo.wait_done", done, 1'b0);
      check("tmo.wait_stall", stall, 1'b1);
    end
    cyc(); mem_valid = 1'b0; memdata_width = 3'b000;
    smp();
    check("tmo.done", done, 1'b1);
    check("tmo.bus_err", bus_err, 1'b1);
    check("tmo.load_data", load_data, 64'd0);
    cyc();
    smp();
    check("tmo.bus_err_pulse", bus_err, 1'b0);

    load_access("lbu2", 3'b111, 64'h0000_0000_5000_0001, 64'h0000_0000_0000_A500, 8'h02,
                64'h0000_0000_0000_00A5);

    // flush in WAIT drains without done or bus_err
    issue("drain", 1'b0, 3'b010, 64'h0000_0000_4000_0060, 64'd0);
    cyc(); req_ready = 1'b1;
    smp();
    cyc(); req_ready = 1'b0; flush = 1'b1; mem_valid = 1'b0; memdata_width = 3'b000;
    smp();
    check("drain.wait_stall", stall, 1'b1);
    drained = 1'b0;
    for (int i = 0; i < 10 && !drained; i++) begin
      cyc(); flush = 1'b0;
      smp();
      check("drain.no_done", done, 1'b0);
      check("drain.no_bus_err", bus_err, 1'b0);
      if (!stall) drained = 1'b1;
    end
    check("drain.exit", drained, 1'b1);
    check("drain.load_data", load_data, 64'h0000_0000_0000_00A5);
    cyc(); resp_valid = 1'b1; resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    smp();
    check("stale_idle.stall", stall, 1'b0);
    cyc(); resp_valid = 1'b0;
    smp();
    check("stale_idle.done", done, 1'b0);
    check("stale_idle.load_data", load_data, 64'h0000_0000_0000_00A5);

    // asynchronous reset while in WAIT
    issue("arst", 1'b0, 3'b010, 64'h0000_0000_4000_0070, 64'h1111_2222_3333_4444);
    cyc(); req_ready = 1'b1;
    smp();
    cyc(); req_ready = 1'b0;
    #2;
    rst = 1'b1; mem_valid = 1'b0; memdata_width = 3'b000;
    #1;
    check("arst.stall", stall, 1'b0);
    check("arst.req_valid", req_valid, 1'b0);
    check("arst.req_addr", req_addr, 64'd0);
    check("arst.req_wmask", req_wmask, 8'd0);
    check("arst.req_wdata", req_wdata, 64'd0);
    check("arst.load_data", load_data, 64'd0);
    check("arst.done", done, 1'b0);
    cyc(); rst = 1'b0;
    cyc(); resp_valid = 1'b1; resp_rdata = 64'h0000_0000_7777_7777;
    smp();
    check("arst.stale_stall", stall, 1'b0);
    cyc(); resp_valid = 1'b0;
    smp();
    check("arst.stale_done", done, 1'b0);
    check("arst.stale_ld", load_data, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
